// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: hex glyph table and output polarity helpers
// used by the scan driver and its decoder.
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9
        7'h77,  // A
        7'h7C,  // b
        7'h39,  // C
        7'h5E,  // d
        7'h79,  // E
        7'h71   // F
    };

    localparam int SEG7_MAX_DIGITS = 8;

    function automatic logic [6:0] seg_drive(input logic [6:0] on, input logic active_low);
        return active_low ? ~on : on;
    endfunction

    function automatic logic bit_drive(input logic on, input logic active_low);
        return active_low ? ~on : on;
    endfunction

    // One-hot anode pattern for up to eight digits; en=0 gives all-inactive.
    function automatic logic [SEG7_MAX_DIGITS-1:0] an_drive(
        input logic [2:0] idx,
        input logic       en,
        input logic       active_low
    );
        logic [SEG7_MAX_DIGITS-1:0] onehot;
        onehot = en ? (SEG7_MAX_DIGITS'(1) << idx) : '0;
        return active_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to seven-segment glyph decoder (active-high).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered display value swapped
// at frame boundaries, per-digit enable, optional leading-zero blanking.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS          = 4,
    parameter int REFRESH_DIV         = 50000,
    parameter bit SEG_ACTIVE_LOW      = 1'b1,
    parameter bit AN_ACTIVE_LOW       = 1'b1,
    parameter bit BLANK_LEADING_ZEROS = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(REFRESH_DIV - 2);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_reg, presc_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic                    presc_tc;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] shadow_value_reg, active_value_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg, active_dp_reg;
    logic                    pending_reg;
    logic                    frame_done_reg;

    assign presc_tc  = (presc_reg == PRESC_LAST);
    assign frame_end = presc_tc && (idx_reg == IDX_LAST);

    always_comb begin
        presc_next = presc_reg + PW'(1);
        idx_next   = idx_reg;
        if (presc_tc) begin
            presc_next = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
    end

    // frame_done is predicted one cycle early so it is a clean register that
    // is high exactly during the boundary cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg        <= '0;
            idx_reg          <= '0;
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            active_value_reg <= '0;
            active_dp_reg    <= '0;
            pending_reg      <= 1'b0;
            frame_done_reg   <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            idx_reg        <= idx_next;
            frame_done_reg <= (presc_reg == PRESC_PRE) && (idx_reg == IDX_LAST);
            if (load) begin
                shadow_value_reg <= value;
                shadow_dp_reg    <= dp_in;
            end
            if (frame_end) begin
                active_value_reg <= load ? value : shadow_value_reg;
                active_dp_reg    <= load ? dp_in : shadow_dp_reg;
                pending_reg      <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi] = active_value_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign blank[gi] = !digit_en[gi];
            end else begin : g_upper
                assign blank[gi] = !digit_en[gi] || (BLANK_LEADING_ZEROS && lead_zero[gi]);
            end
        end
    endgenerate

    // lead_zero[i]: nibble i and every nibble above it are zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (nib[i] == 4'h0);
            lead_zero[i] = zero_run;
        end
    end

    logic [3:0]                 cur_nib;
    logic                       cur_blank;
    logic                       cur_dp;
    logic [6:0]                 dec_seg;
    logic [SEG7_MAX_DIGITS-1:0] an_full;

    assign cur_nib   = nib[idx_reg];
    assign cur_blank = blank[idx_reg];
    assign cur_dp    = active_dp_reg[idx_reg];

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [NUM_DIGITS-1:0] an_reg;

    assign an_full = an_drive(3'(idx_reg), !(rst || cur_blank), AN_ACTIVE_LOW);

    // seg, dp and an all load on the same edge from the same index.
    always_ff @(posedge clk) begin
        if (rst || cur_blank) begin
            seg_reg <= seg_drive(7'h00, SEG_ACTIVE_LOW);
            dp_reg  <= bit_drive(1'b0, SEG_ACTIVE_LOW);
        end else begin
            seg_reg <= seg_drive(dec_seg, SEG_ACTIVE_LOW);
            dp_reg  <= bit_drive(cur_dp, SEG_ACTIVE_LOW);
        end
        an_reg <= an_full[NUM_DIGITS-1:0];
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign pending    = pending_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized and directed bench for seven_seg_scan_driver; two instances differ
// only in leading-zero blanking and are checked against an arithmetic model.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       pend_a, pend_b;
    logic       fd_a, fd_b;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZEROS(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .seg(seg_a), .dp(dp_a), .an(an_a),
        .pending(pend_a), .frame_done(fd_a)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZEROS(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .digit_en(digit_en), .seg(seg_b), .dp(dp_b), .an(an_b),
        .pending(pend_b), .frame_done(fd_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since reset release, plus the two display buffers.
    int          cyc;
    logic [15:0] m_active, m_shadow;
    logic [3:0]  m_act_dp, m_sh_dp;
    logic        m_pend;
    logic [6:0]  ex_seg [2];
    logic        ex_dp [2];
    logic [3:0]  ex_an [2];
    logic        ex_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void predict(input logic blz, output logic [6:0] s,
                                    output logic p, output logic [3:0] a);
        int   d;
        int   hi;
        logic blank;
        d  = (cyc / DIV) % ND;
        hi = 0;
        for (int i = 0; i < ND; i++)
            if (m_active[4*i +: 4] != 4'h0) hi = i;
        blank = !digit_en[d] || (blz && d > hi);
        if (blank) begin
            s = 7'h7F;
            p = 1'b1;
            a = 4'hF;
        end else begin
            s = ~HEX_TBL[m_active[4*d +: 4]];
            p = ~m_act_dp[d];
            a = ~(4'b0001 << d);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            cyc      = 0;
            m_active = '0;
            m_shadow = '0;
            m_act_dp = '0;
            m_sh_dp  = '0;
            m_pend   = 1'b0;
            for (int k = 0; k < 2; k++) begin
                ex_seg[k] = 7'h7F;
                ex_dp[k]  = 1'b1;
                ex_an[k]  = 4'hF;
            end
        end else begin
            predict(1'b0, ex_seg[0], ex_dp[0], ex_an[0]);
            predict(1'b1, ex_seg[1], ex_dp[1], ex_an[1]);
            if (load) begin
                m_shadow = value;
                m_sh_dp  = dp_in;
                $display("load value=%h dp=%b frame_pos=%0d", value, dp_in, cyc % FRAME);
            end
            if (cyc % FRAME == FRAME - 1) begin
                m_active = m_shadow;
                m_act_dp = m_sh_dp;
                m_pend   = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            cyc++;
        end
        ex_fd = (cyc % FRAME == FRAME - 1);
        #1;
        check("seg_a", 32'(seg_a), 32'(ex_seg[0]));
        check("dp_a", 32'(dp_a), 32'(ex_dp[0]));
        check("an_a", 32'(an_a), 32'(ex_an[0]));
        check("pending_a", 32'(pend_a), 32'(m_pend));
        check("frame_done_a", 32'(fd_a), 32'(ex_fd));
        check("seg_b", 32'(seg_b), 32'(ex_seg[1]));
        check("dp_b", 32'(dp_b), 32'(ex_dp[1]));
        check("an_b", 32'(an_b), 32'(ex_an[1]));
        check("pending_b", 32'(pend_b), 32'(m_pend));
        check("frame_done_b", 32'(fd_b), 32'(ex_fd));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp_in = d;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        digit_en = 4'hF;
        cyc      = 0;
        step();
        step();
        rst = 1'b0;
        step();

        // Loaded value waits for the boundary, then scans out.
        do_load(16'h12AF, 4'b0101);
        repeat (40) step();

        // Two loads inside one frame: the later one wins.
        while (cyc % FRAME != 2) step();
        do_load(16'h1111, 4'b0000);
        repeat (3) step();
        do_load(16'h2222, 4'b1000);
        repeat (30) step();

        // Load exactly on the boundary cycle is applied at once.
        while (cyc % FRAME != FRAME - 1) step();
        do_load(16'h3C5D, 4'b0010);
        repeat (20) step();

        // Per-digit enable masks slot 2.
        digit_en = 4'b1011;
        do_load(16'h8888, 4'b1111);
        repeat (40) step();
        digit_en = 4'hF;

        // Leading-zero blanking cases.
        do_load(16'h0050, 4'b1110);
        repeat (36) step();
        do_load(16'h0000, 4'b0001);
        repeat (36) step();
        do_load(16'h0E00, 4'b0000);
        repeat (36) step();

        // Reset mid-frame with a pending load discards it.
        while (cyc % FRAME != 5) step();
        do_load(16'h9ABC, 4'b1111);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        // Randomized traffic.
        repeat (3000) begin
            load  = ($urandom_range(0, 15) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst  = 1'b0;
        load = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clk cycles each digit is driven; legal range >= 2.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, 1 = seg/dp outputs asserted low.
REQ-004 Parameter AN_ACTIVE_LOW, default 1, 1 = an outputs asserted low.
REQ-005 Parameter BLANK_LEADING_ZEROS, default 0, 1 = suppress zero digits above the most significant nonzero digit.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 load  input  1  one-cycle strobe capturing value and dp_in.
REQ-009 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
REQ-010 dp_in  input  NUM_DIGITS  decimal point request per digit, captured with value.
REQ-011 digit_en  input  NUM_DIGITS  live per-digit enable, not captured.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, bit 0 = a, registered.
REQ-013 dp  output  1  decimal point, registered.
REQ-014 an  output  NUM_DIGITS  digit anode select, at most one asserted, registered.
REQ-015 pending  output  1  high while a loaded value awaits a frame boundary.
REQ-016 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-017 Decode (active-high form) SHALL be: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001; SEG_ACTIVE_LOW inverts seg and dp.
REQ-018 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; terminal count advances digit index by one, wrapping NUM_DIGITS-1 -> 0.
REQ-019 Frame boundary SHALL be terminal count while index = NUM_DIGITS-1; frame length = NUM_DIGITS*REFRESH_DIV cycles; frame_done asserts in that cycle only.
REQ-020 seg, dp, an SHALL reflect the current index with exactly one cycle of latency, all three updating in the same cycle (no cross-digit ghosting).
REQ-021 load SHALL copy value/dp_in into a shadow register and set pending; shadow SHALL be copied to the active register at the next frame boundary, clearing pending.
REQ-022 load while pending SHALL overwrite shadow; last load before the boundary wins.
REQ-023 load coinciding with a frame boundary SHALL write both shadow and active with the new data and leave pending low.
REQ-024 Digit i with digit_en[i]=0 SHALL drive an all-inactive, seg all-off and dp off for its slot; the scan continues unchanged.
REQ-025 With BLANK_LEADING_ZEROS=1, digits above the highest nonzero active nibble SHALL be blanked as in REQ-024; digit 0 SHALL never be blanked by this rule.
REQ-026 dp SHALL assert for digit i iff active dp bit i = 1 and digit i is not blanked.

Reset
REQ-027 rst SHALL clear prescaler, index, shadow, active and pending to 0 and frame_done to 0.
REQ-028 During rst, an SHALL be all-inactive and seg/dp all-off (polarity-adjusted); the first cycle after rst deasserts SHALL display digit 0 of active.
REQ-029 rst mid-frame or with pending high SHALL discard shadow data and restart the scan at digit 0.

Structure
REQ-030 Decode table constants and polarity helpers SHALL live in a shared package seg7_pkg.
REQ-031 Decode SHALL be a separate combinational sub-module seg7_decode (4-bit in, 7-bit active-high out), one instance.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low)
REQ-032 rst for 2 cycles -> an=1111, seg=1111111 during rst; next cycle an=1110, seg=1000000 ("0").
REQ-033 load value=16'h12AF at cycle 1 -> pending=1 until cycle-16 boundary; then digit 0 seg=0001110, an=1110; digit 3 seg=1111001, an=0111.
REQ-034 loads 16'h1111 then 16'h2222 within one frame -> only 2222 displayed after boundary; load on the boundary cycle -> applied immediately, pending=0.
REQ-035 digit_en=1011, value=16'h8888 -> slot 2 an=1111, seg=1111111; others show 0000000.
REQ-036 BLANK_LEADING_ZEROS=1, value=16'h0050 -> digits 3,2 blanked, digit 1 seg=0010010, digit 0 seg=1000000; value=0 -> only digit 0 lit.
REQ-037 rst asserted mid-frame with pending=1 -> pending=0, index 0, prior shadow never displayed; frame_done pulses every 16 cycles thereafter.
